// File: rtl/microcode_sequencer.sv
// microcode_sequencer: T-state counter and opcode/flag decode into the bus computer control word
module microcode_sequencer #(
  parameter int STEPS  = 5,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        insn,
  input  logic              carry_in,
  input  logic              zero_in,
  output logic              hlt,
  output logic              mi,
  output logic              ri,
  output logic              ro,
  output logic              io,
  output logic              ii,
  output logic              ai,
  output logic              ao,
  output logic              sumo,
  output logic              sub,
  output logic              bi,
  output logic              oi,
  output logic              ce,
  output logic              co,
  output logic              j,
  output logic              fi,
  output logic [STEP_W-1:0] step,
  output logic              flag_c,
  output logic              flag_z
);
  localparam logic [15:0] wHlt = 16'h8000, wMi = 16'h4000, wRi = 16'h2000, wRo = 16'h1000;
  localparam logic [15:0] wIo = 16'h0800, wIi = 16'h0400, wAi = 16'h0200, wAo = 16'h0100;
  localparam logic [15:0] wSumo = 16'h0080, wSub = 16'h0040, wBi = 16'h0020, wOi = 16'h0010;
  localparam logic [15:0] wCe = 16'h0008, wCo = 16'h0004, wJ = 16'h0002, wFi = 16'h0001;
  localparam logic [STEP_W-1:0] lastStep = STEP_W'(STEPS - 1);

  function automatic logic [15:0] decode(input logic [STEP_W-1:0] s, input logic [3:0] op,
                                         input logic fc, input logic fz);
    logic [15:0] w;
    w = '0;
    if (s == STEP_W'(0))
      w = wCo | wMi;
    else if (s == STEP_W'(1))
      w = wRo | wIi | wCe;
    else if (s == STEP_W'(2))
      case (op)
        4'h1, 4'h2, 4'h3, 4'h4: w = wIo | wMi;
        4'h5: w = wIo | wAi;
        4'h6: w = wIo | wJ;
        4'h7: w = fc ? (wIo | wJ) : '0;
        4'h8: w = fz ? (wIo | wJ) : '0;
        4'hE: w = wAo | wOi;
        4'hF: w = wHlt;
        default: w = '0;
      endcase
    else if (s == STEP_W'(3))
      case (op)
        4'h1: w = wRo | wAi;
        4'h2, 4'h3: w = wRo | wBi;
        4'h4: w = wAo | wRi;
        default: w = '0;
      endcase
    else if (s == STEP_W'(4))
      case (op)
        4'h2: w = wSumo | wAi | wFi;
        4'h3: w = wSumo | wAi | wSub | wFi;
        default: w = '0;
      endcase
    return w;
  endfunction

  logic [15:0] word, nextWord;
  logic        unused;

  assign unused = ^insn[3:0];
  assign word = decode(step, insn[7:4], flag_c, flag_z);
  assign nextWord = decode(step + 1'b1, insn[7:4], flag_c, flag_z);
  assign {hlt, mi, ri, ro, io, ii, ai, ao, sumo, sub, bi, oi, ce, co, j, fi} = word;

  always_ff @(posedge clk) begin
    if (!rst) begin
      step   <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      if (fi) begin
        flag_c <= carry_in;
        flag_z <= zero_in;
      end
      if (!hlt) step <= (step == lastStep || nextWord == '0) ? '0 : step + 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (rst) assert ($countones({co, ro, io, ao, sumo}) <= 1);
endmodule
